// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the decode hazard controller: register
// index width, the register-zero constant, the NOP slot encoding, the FSM
// state type and the RAW compare helper.
package decode_hazard_ctrl_pkg;

    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Destination bookkeeping for one older pipeline stage.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              ld;
    } slot_t;

    localparam slot_t SLOT_NOP = '{rd: REG_ZERO, wr: 1'b0, ld: 1'b0};

    // True when an instruction reading rs/rt depends on the value the slot
    // will write. Register zero is hard-wired and never creates a dependency.
    function automatic logic raw_hit(
        input slot_t             s,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rt,
        input logic              uses_rs,
        input logic              uses_rt
    );
        return s.wr && (s.rd != REG_ZERO) &&
               ((uses_rs && (rs == s.rd)) || (uses_rt && (rt == s.rd)));
    endfunction

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// Decode-stage bundle: the ID instruction fields and EX status coming in,
// the fetch/decode latch enables going out.
interface decode_hazard_ctrl_if #(
    parameter int REG_AW = decode_hazard_ctrl_pkg::REG_AW
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              ex_branch_taken;
    logic              ex_busy;
    logic              pc_we;
    logic              ifid_we;
    logic              ifid_flush;
    logic              idex_we;
    logic              idex_bubble;
    logic              hazard_stall;

    // Pipeline side: presents the instruction and EX status.
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rd, id_reg_write, id_mem_read, ex_branch_taken, ex_busy,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, hazard_stall
    );

    // Controller side: consumes the instruction, drives the enables.
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rd, id_reg_write, id_mem_read, ex_branch_taken, ex_busy,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, hazard_stall
    );

endinterface

// File: rtl/decode_hazard_ctrl_dest_tracker.sv
// EX/MEM destination shift register plus the RAW compares of the ID
// instruction against both older slots.
module dest_tracker
    import decode_hazard_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_hold,
    input  logic              i_issue,
    input  slot_t             i_id_slot,
    input  logic [REG_AW-1:0] i_rs,
    input  logic [REG_AW-1:0] i_rt,
    input  logic              i_uses_rs,
    input  logic              i_uses_rt,
    output logic              o_raw_ex,
    output logic              o_raw_mem,
    output logic              o_ex_ld
);

    slot_t r_ex_slot;
    slot_t r_mem_slot;

    // Advance EX->MEM each unheld edge; a non-issued cycle injects a NOP.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so r_mem_slot takes the old r_ex_slot value.
        if (rst) begin
            r_ex_slot  <= SLOT_NOP;
            r_mem_slot <= SLOT_NOP;
        end else if (!i_hold) begin
            r_ex_slot  <= i_issue ? i_id_slot : SLOT_NOP;
            r_mem_slot <= r_ex_slot;
        end
    end

    // Dependency of the ID instruction on each older slot.
    always_comb begin
        o_raw_ex  = raw_hit(r_ex_slot,  i_rs, i_rt, i_uses_rs, i_uses_rt);
        o_raw_mem = raw_hit(r_mem_slot, i_rs, i_rt, i_uses_rs, i_uses_rt);
        o_ex_ld   = r_ex_slot.ld;
    end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode hazard controller: tracks older destinations, detects RAW hazards,
// counts post-branch flush cycles and drives the PC, IF/ID and ID/EX enables.
module decode_hazard_ctrl
    import decode_hazard_ctrl_pkg::state_t;
    import decode_hazard_ctrl_pkg::ST_RUN;
    import decode_hazard_ctrl_pkg::ST_FLUSH;
    import decode_hazard_ctrl_pkg::slot_t;
#(
    parameter bit FWD_EN       = 1'b1,
    parameter int FLUSH_CYCLES = 1,
    parameter int REG_AW       = decode_hazard_ctrl_pkg::REG_AW
) (
    input logic                 clk,
    input logic                 rst,
    decode_hazard_ctrl_if.slave bus
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : g_bad_flush_cycles
        $error("FLUSH_CYCLES must be in 1..3");
    end
    if (REG_AW != decode_hazard_ctrl_pkg::REG_AW) begin : g_bad_reg_aw
        $error("REG_AW must match the pipeline package width");
    end

    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    state_t     r_state;
    logic [1:0] r_flush_cnt;

    slot_t w_id_slot;
    logic  w_raw_ex;
    logic  w_raw_mem;
    logic  w_ex_ld;
    logic  w_hz;
    logic  w_flush;
    logic  w_issue;

    assign w_id_slot = '{rd: bus.id_rd, wr: bus.id_reg_write, ld: bus.id_mem_read};
    assign w_flush   = bus.ex_branch_taken || (r_state == ST_FLUSH);

    dest_tracker u_dest_tracker (
        .clk       (clk),
        .rst       (rst),
        .i_hold    (bus.ex_busy),
        .i_issue   (w_issue),
        .i_id_slot (w_id_slot),
        .i_rs      (bus.id_rs),
        .i_rt      (bus.id_rt),
        .i_uses_rs (bus.id_uses_rs),
        .i_uses_rt (bus.id_uses_rt),
        .o_raw_ex  (w_raw_ex),
        .o_raw_mem (w_raw_mem),
        .o_ex_ld   (w_ex_ld)
    );

    // With forwarding only a load in EX cannot be bypassed in time.
    always_comb begin
        if (FWD_EN) begin
            w_hz = bus.id_valid && w_raw_ex && w_ex_ld;
        end else begin
            w_hz = bus.id_valid && (w_raw_ex || w_raw_mem);
        end
    end

    // Priority mux: reset, flush, EX hold, RAW stall, normal issue.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        bus.pc_we        = 1'b1;
        bus.ifid_we      = 1'b1;
        bus.ifid_flush   = 1'b0;
        bus.idex_we      = 1'b1;
        bus.idex_bubble  = 1'b0;
        bus.hazard_stall = 1'b0;
        w_issue          = 1'b0;
        if (rst) begin
            bus.pc_we       = 1'b0;
            bus.ifid_we     = 1'b0;
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
        end else if (w_flush) begin
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
        end else if (bus.ex_busy) begin
            bus.pc_we       = 1'b0;
            bus.ifid_we     = 1'b0;
            bus.idex_we     = 1'b0;
        end else if (w_hz) begin
            bus.pc_we        = 1'b0;
            bus.ifid_we      = 1'b0;
            bus.idex_bubble  = 1'b1;
            bus.hazard_stall = 1'b1;
        end else begin
            w_issue = bus.id_valid;
        end
    end

    // Flush FSM: the branch cycle itself is the first flush cycle, FLUSH
    // covers the remaining ones and pauses while EX is busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
        end else if (bus.ex_branch_taken) begin
            if (FLUSH_CYCLES > 1) begin
                r_state     <= ST_FLUSH;
                r_flush_cnt <= FLUSH_RELOAD;
            end else begin
                r_state     <= ST_RUN;
                r_flush_cnt <= '0;
            end
        end else if ((r_state == ST_FLUSH) && !bus.ex_busy) begin
            if (r_flush_cnt <= 2'd1) begin
                r_state     <= ST_RUN;
                r_flush_cnt <= '0;
            end else begin
                r_flush_cnt <= r_flush_cnt - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench: two controllers (forwarding / no forwarding) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_decode_hazard_ctrl;

    // Output vector order: {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, hazard_stall}
    localparam logic [5:0] OUT_RST   = 6'b001110;
    localparam logic [5:0] OUT_FLUSH = 6'b111110;
    localparam logic [5:0] OUT_HOLD  = 6'b000000;
    localparam logic [5:0] OUT_STALL = 6'b000111;
    localparam logic [5:0] OUT_RUN   = 6'b110100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       i_rst;
    logic       i_valid;
    logic [4:0] i_rs;
    logic [4:0] i_rt;
    logic [4:0] i_rd;
    logic       i_urs;
    logic       i_urt;
    logic       i_wr;
    logic       i_ld;
    logic       i_br;
    logic       i_busy;

    decode_hazard_ctrl_if bus0 ();
    decode_hazard_ctrl_if bus1 ();

    assign bus0.id_valid = i_valid;         assign bus1.id_valid = i_valid;
    assign bus0.id_rs = i_rs;               assign bus1.id_rs = i_rs;
    assign bus0.id_rt = i_rt;               assign bus1.id_rt = i_rt;
    assign bus0.id_uses_rs = i_urs;         assign bus1.id_uses_rs = i_urs;
    assign bus0.id_uses_rt = i_urt;         assign bus1.id_uses_rt = i_urt;
    assign bus0.id_rd = i_rd;               assign bus1.id_rd = i_rd;
    assign bus0.id_reg_write = i_wr;        assign bus1.id_reg_write = i_wr;
    assign bus0.id_mem_read = i_ld;         assign bus1.id_mem_read = i_ld;
    assign bus0.ex_branch_taken = i_br;     assign bus1.ex_branch_taken = i_br;
    assign bus0.ex_busy = i_busy;           assign bus1.ex_busy = i_busy;

    decode_hazard_ctrl #(.FWD_EN(1'b1), .FLUSH_CYCLES(2), .REG_AW(5)) dut_fwd (
        .clk (clk), .rst (i_rst), .bus (bus0)
    );
    decode_hazard_ctrl #(.FWD_EN(1'b0), .FLUSH_CYCLES(3), .REG_AW(5)) dut_nofwd (
        .clk (clk), .rst (i_rst), .bus (bus1)
    );

    logic [5:0] w_out [2];
    assign w_out[0] = {bus0.pc_we, bus0.ifid_we, bus0.ifid_flush,
                       bus0.idex_we, bus0.idex_bubble, bus0.hazard_stall};
    assign w_out[1] = {bus1.pc_we, bus1.ifid_we, bus1.ifid_flush,
                       bus1.idex_we, bus1.idex_bubble, bus1.hazard_stall};

    int n_checks = 0;
    int n_errors = 0;
    int n_cycle  = 0;
    int n_stall [2];
    int n_flush [2];

    // Model state: older instructions (index 0 = one ahead of ID, 1 = two
    // ahead) and how many flush cycles remain after the current one.
    int         m_rd [2][2];
    bit         m_wr [2][2];
    bit         m_ld [2][2];
    int         m_flush_left [2];
    logic [5:0] m_exp [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, n_cycle, got, exp);
        end
    endtask

    function automatic bit model_fwd(input int k);
        return k == 0;
    endfunction

    function automatic int model_flush_n(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic logic [5:0] model_exp(input int k);
        bit dep;
        bit hz;
        if (i_rst) return OUT_RST;
        hz = 1'b0;
        for (int d = 0; d < 2; d++) begin
            dep = m_wr[k][d] && (m_rd[k][d] != 0) &&
                  ((i_urs && int'(i_rs) == m_rd[k][d]) || (i_urt && int'(i_rt) == m_rd[k][d]));
            if (i_valid && dep && (!model_fwd(k) || (d == 0 && m_ld[k][d]))) hz = 1'b1;
        end
        if (i_br || m_flush_left[k] > 0) return OUT_FLUSH;
        if (i_busy) return OUT_HOLD;
        if (hz) return OUT_STALL;
        return OUT_RUN;
    endfunction

    task automatic model_advance(input int k);
        if (i_rst) begin
            for (int d = 0; d < 2; d++) begin
                m_rd[k][d] = 0; m_wr[k][d] = 1'b0; m_ld[k][d] = 1'b0;
            end
            m_flush_left[k] = 0;
        end else begin
            if (!i_busy) begin
                m_rd[k][1] = m_rd[k][0]; m_wr[k][1] = m_wr[k][0]; m_ld[k][1] = m_ld[k][0];
                if (m_exp[k] == OUT_RUN && i_valid) begin
                    m_rd[k][0] = int'(i_rd); m_wr[k][0] = i_wr; m_ld[k][0] = i_ld;
                end else begin
                    m_rd[k][0] = 0; m_wr[k][0] = 1'b0; m_ld[k][0] = 1'b0;
                end
            end
            if (i_br) m_flush_left[k] = model_flush_n(k) - 1;
            else if (m_flush_left[k] > 0 && !i_busy) m_flush_left[k]--;
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic run_cycle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            m_exp[k] = model_exp(k);
            check($sformatf("out_dut%0d", k), 32'(w_out[k]), 32'(m_exp[k]));
            if (w_out[k][0]) n_stall[k]++;
            if (w_out[k][3]) n_flush[k]++;
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_advance(k);
        n_cycle++;
        #1;
    endtask

    task automatic set_id(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                          input int rd, input bit wr, input bit ld);
        i_valid = v; i_rs = 5'(rs); i_rt = 5'(rt); i_urs = urs; i_urt = urt;
        i_rd = 5'(rd); i_wr = wr; i_ld = ld;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin
            n_stall[k] = 0; n_flush[k] = 0;
        end
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        i_br = 1'b0; i_busy = 1'b0;
        repeat (n) run_cycle();
    endtask

    task automatic randomize_inputs();
        i_valid = ($urandom_range(0, 99) < 85);
        i_rs    = 5'($urandom_range(0, 7));
        i_rt    = 5'($urandom_range(0, 7));
        i_rd    = 5'($urandom_range(0, 7));
        i_urs   = ($urandom_range(0, 99) < 60);
        i_urt   = ($urandom_range(0, 99) < 60);
        i_wr    = ($urandom_range(0, 99) < 70);
        i_ld    = ($urandom_range(0, 99) < 30);
        i_br    = ($urandom_range(0, 99) < 8);
        i_busy  = ($urandom_range(0, 99) < 12);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int d = 0; d < 2; d++) begin
                m_rd[k][d] = 0; m_wr[k][d] = 1'b0; m_ld[k][d] = 1'b0;
            end
            m_flush_left[k] = 0;
        end
        clear_counts();

        // Reset held for three cycles with arbitrary inputs.
        i_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            randomize_inputs();
            run_cycle();
        end
        i_rst = 1'b0; i_br = 1'b0; i_busy = 1'b0;
        set_id(1, 1, 2, 1, 1, 3, 1, 0);
        clear_counts();
        run_cycle();
        check("post_rst_no_flush", 32'(n_flush[0] + n_flush[1]), 0);
        idle(3);

        // Load-use on r5.
        set_id(1, 0, 0, 0, 0, 5, 1, 1); run_cycle();
        clear_counts();
        set_id(1, 5, 0, 1, 0, 6, 1, 0); repeat (4) run_cycle();
        check("lu_stall_fwd", 32'(n_stall[0]), 1);
        check("lu_stall_nofwd", 32'(n_stall[1]), 2);
        idle(3);

        // Load of r0 followed by a read of r0: never a hazard.
        set_id(1, 0, 0, 0, 0, 0, 1, 1); run_cycle();
        clear_counts();
        set_id(1, 0, 0, 1, 0, 6, 1, 0); repeat (4) run_cycle();
        check("r0_stall_fwd", 32'(n_stall[0]), 0);
        check("r0_stall_nofwd", 32'(n_stall[1]), 0);
        idle(3);

        // ALU producer r7, consumer reads rt=7.
        set_id(1, 0, 0, 0, 0, 7, 1, 0); run_cycle();
        clear_counts();
        set_id(1, 0, 7, 0, 1, 8, 1, 0); repeat (4) run_cycle();
        check("alu_stall_fwd", 32'(n_stall[0]), 0);
        check("alu_stall_nofwd", 32'(n_stall[1]), 2);
        idle(3);

        // Single-cycle taken branch.
        clear_counts();
        set_id(1, 1, 2, 1, 1, 3, 1, 0);
        i_br = 1'b1; run_cycle();
        i_br = 1'b0; repeat (5) run_cycle();
        check("br_flush_fwd", 32'(n_flush[0]), 2);
        check("br_flush_nofwd", 32'(n_flush[1]), 3);
        idle(3);

        // Branch coincident with a load-use stall.
        set_id(1, 0, 0, 0, 0, 5, 1, 1); run_cycle();
        clear_counts();
        set_id(1, 5, 0, 1, 0, 6, 1, 0);
        i_br = 1'b1; run_cycle();
        check("br_vs_hz_stall0", 32'(w_out[0][0]), 0);
        i_br = 1'b0; repeat (4) run_cycle();
        check("br_hz_stall_fwd", 32'(n_stall[0]), 0);
        check("br_hz_stall_nofwd", 32'(n_stall[1]), 0);
        idle(4);

        // EX busy for four cycles with a load-use hazard pending.
        set_id(1, 0, 0, 0, 0, 5, 1, 1); run_cycle();
        clear_counts();
        set_id(1, 5, 0, 1, 0, 6, 1, 0);
        i_busy = 1'b1; repeat (4) run_cycle();
        check("busy_no_stall", 32'(n_stall[0] + n_stall[1]), 0);
        i_busy = 1'b0; repeat (4) run_cycle();
        check("busy_rel_stall_fwd", 32'(n_stall[0]), 1);
        check("busy_rel_stall_nofwd", 32'(n_stall[1]), 2);
        idle(3);

        // Reset asserted in the middle of a flush.
        set_id(1, 1, 2, 1, 1, 3, 1, 0);
        i_br = 1'b1; run_cycle();
        i_br = 1'b0; i_rst = 1'b1; run_cycle();
        i_rst = 1'b0;
        clear_counts();
        run_cycle();
        check("rst_flush_fwd", 32'(n_flush[0]), 0);
        check("rst_flush_nofwd", 32'(n_flush[1]), 0);

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 3000; c++) begin
            randomize_inputs();
            i_rst = ($urandom_range(0, 99) < 2);
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout cycle=%0d got=running exp=finished", n_cycle);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decode_hazard_ctrl.md
Name: decode_hazard_ctrl

Overview:
- Pipeline controller for the ID/EX decode latch, the IF/ID latch and the PC register.
- Holds a registered copy of the destination registers in EX and MEM.
- Detects RAW hazards between the instruction in ID and those older instructions.
- Drives stall, bubble and flush enables so the decode latch only captures legal instructions.
- Sits beside the decode stage; all enables go to the fetch/decode latches.

Parameters:
- FWD_EN, 1, 1 = EX/MEM forwarding exists (stall only on load-use); 0 = stall on any RAW against EX or MEM.
- FLUSH_CYCLES, 1, number of cycles IF/ID stays flushed after a taken branch (range 1..3).
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_AW  source A index
- id_rt  in  REG_AW  source B index
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt
- id_rd  in  REG_AW  destination index
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- ex_busy  in  1  multi-cycle EX unit requests a hold
- pc_we  out  1  PC register write enable
- ifid_we  out  1  IF/ID latch write enable
- ifid_flush  out  1  IF/ID latch loads a NOP
- idex_we  out  1  ID/EX (decode latch) write enable
- idex_bubble  out  1  ID/EX latch loads a NOP (control zeroed)
- hazard_stall  out  1  debug: a RAW stall is active this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Outputs while rst=1 (combinational override):
  - pc_we=0, ifid_we=0, idex_we=1.
  - ifid_flush=1, idex_bubble=1, hazard_stall=0.
- On the first edge with rst=1: tracking regs clear (ex_rd=0, ex_wr=0, ex_ld=0, mem_rd=0, mem_wr=0), flush_cnt=0, FSM=RUN.
- Tracking registers advance on every edge where ex_busy=0:
  - EX slot <= ID fields when the instruction is issued, else a NOP.
  - MEM slot <= EX slot.
  - When ex_busy=1, both slots hold.
- Register 0 never causes a hazard. Comparisons are full REG_AW-bit equality.
- raw_ex = ex_wr && ex_rd!=0 && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd)). raw_mem is the same check against mem_rd and mem_wr.
- hz (combinational):
  - FWD_EN=1: hz = id_valid && raw_ex && ex_ld.
  - FWD_EN=0: hz = id_valid && (raw_ex || raw_mem).
- FSM states:
  - RUN: normal issue.
  - FLUSH: counting flush cycles after a taken branch.
- Transitions:
  - RUN to FLUSH when ex_branch_taken=1 and FLUSH_CYCLES>1; flush_cnt <= FLUSH_CYCLES-1.
  - FLUSH: flush_cnt decrements each cycle; return to RUN when flush_cnt reaches 0.
  - ex_branch_taken in FLUSH reloads the counter.
- Priority, highest first, evaluated every cycle:
  - 1) ex_branch_taken or state FLUSH: pc_we=1, ifid_we=1, ifid_flush=1, idex_we=1, idex_bubble=1.
  - 2) ex_busy: pc_we=0, ifid_we=0, idex_we=0, idex_bubble=0. Everything holds and the tracking slots freeze.
  - 3) hz: pc_we=0, ifid_we=0, idex_we=1, idex_bubble=1, hazard_stall=1. A bubble enters EX and the ID instruction is re-evaluated next cycle.
  - 4) otherwise: pc_we=1, ifid_we=1, idex_we=1, ifid_flush=0, idex_bubble=0.
- "Issued" means case 4 with id_valid=1.
- Load-use stall length:
  - FWD_EN=1: exactly 1 cycle.
  - FWD_EN=0: at most 2 cycles (producer in EX), or 1 cycle (producer in MEM).
- A branch taken during a hazard stall: the flush wins and the stalled ID instruction is discarded.
- ex_busy during FLUSH: the flush still wins. The FLUSH counter does not decrement while ex_busy=1.
- Asserting rst mid-stall or mid-flush returns to the reset state on that edge. No pending hazard survives reset.
- Latency: all enables are combinational from the current inputs and registered state. No output is delayed by an extra register.

Decomposition:
- Shared pipeline package holds:
  - REG_AW and the register-zero constant.
  - NOP encoding.
  - FSM state typedef (RUN, FLUSH).
  - The stage-slot struct {rd, wr, ld}.
- One natural sub-module, dest_tracker: the EX/MEM slot shift register with a hold input and the raw_ex/raw_mem compare logic. The FSM and priority mux stay in the top.

Test Plan:
- Reset: hold rst=1 for 3 cycles, with any inputs -> pc_we=0, ifid_flush=1, idex_bubble=1. The first cycle after release with an independent instruction gives pc_we=1, idex_bubble=0.
- Load-use, FWD_EN=1: issue "lw r5" then ID reads rs=5 -> exactly 1 cycle of pc_we=0, idex_bubble=1, hazard_stall=1, then issue.
- Same sequence with rs=0 -> no stall.
- ALU RAW, FWD_EN=0: issue "add r7" then ID uses rt=7 -> 2 stall cycles. With FWD_EN=1 -> 0 stall cycles.
- Branch, FLUSH_CYCLES=2: ex_branch_taken pulse for 1 cycle -> ifid_flush=1 and idex_bubble=1 for 2 consecutive cycles, then RUN.
- A branch coincident with a load-use stall -> flush outputs win and hazard_stall=0.
- Multi-cycle hold: ex_busy=1 for 4 cycles while a load-use hazard is present -> all enables 0 and tracking slots unchanged for those 4 cycles. After release: 1 stall cycle, then issue.
- rst asserted during FLUSH (counter at 1) -> the next cycle is in the reset state with FSM=RUN and no further flush.
